// File: rtl/event_merge_scheduler_pkg.sv
// Shared constants and elaboration helpers for the event merge scheduler.
package event_merge_scheduler_pkg;

   localparam int unsigned HOLDOFF_WIDTH = 16;

   // Largest value a counter of the given width can hold.
   function automatic int unsigned count_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

   // Ceiling log2 with a floor of one bit, so single-source builds still get an index.
   function automatic int unsigned clog2_min1(input int unsigned value);
      int unsigned w;
      w = 1;
      while (((32'd1 << w) < value) && (w < 32'd31)) w++;
      return w;
   endfunction

endpackage

// File: rtl/event_merge_scheduler_if.sv
// Valid/ready event channel carrying a source index and a merged pulse count.
interface event_merge_scheduler_if import event_merge_scheduler_pkg::*; #(
   parameter int unsigned INDEX_WIDTH = 2,
   parameter int unsigned COUNT_WIDTH = 4
);
   logic [INDEX_WIDTH-1:0] m_event_index;
   logic [COUNT_WIDTH-1:0] m_event_count;
   logic                   m_event_valid;
   logic                   m_event_ready;

   modport master (
      output m_event_index, m_event_count, m_event_valid,
      input  m_event_ready
   );

   modport slave (
      input  m_event_index, m_event_count, m_event_valid,
      output m_event_ready
   );
endinterface

// File: rtl/event_merge_rr_select.sv
// Combinational round-robin select: lowest requesting index at or above ptr, else lowest overall.
module event_merge_rr_select import event_merge_scheduler_pkg::*; #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = clog2_min1(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          gnt_valid_c_o,
   output logic [IW-1:0] gnt_index_c_o
);

   always_comb begin
      gnt_valid_c_o = 1'b0;
      gnt_index_c_o = '0;
      // Wrapped candidates first, then the ones at/above ptr override them.
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            gnt_valid_c_o = 1'b1;
            gnt_index_c_o = IW'(i);
         end
      end
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req_i[i] && (IW'(i) >= ptr_i)) begin
            gnt_valid_c_o = 1'b1;
            gnt_index_c_o = IW'(i);
         end
      end
   end

endmodule

// File: rtl/event_merge_scheduler.sv
// Per-source saturating pulse counters merged into one round-robin valid/ready event stream.
// Optional per-source holdoff timers: define EVENT_MERGE_SCHEDULER_HOLDOFF_EN.
module event_merge_scheduler import event_merge_scheduler_pkg::*; #(
   parameter int unsigned INPUT_WIDTH = 4,
   parameter int unsigned INDEX_WIDTH = clog2_min1(INPUT_WIDTH),
   parameter int unsigned COUNT_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [INPUT_WIDTH-1:0]   pulse_in,
   input  logic [INPUT_WIDTH-1:0]   enable,
`ifdef EVENT_MERGE_SCHEDULER_HOLDOFF_EN
   input  logic [HOLDOFF_WIDTH-1:0] holdoff_time,
`endif
   event_merge_scheduler_if.master  m_event,
   output logic [INPUT_WIDTH-1:0]   pending,
   output logic [INPUT_WIDTH-1:0]   overflow
);

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(count_max(COUNT_WIDTH));

   logic [COUNT_WIDTH-1:0] cnt_q [INPUT_WIDTH];
   logic [COUNT_WIDTH-1:0] cnt_d [INPUT_WIDTH];
   logic [COUNT_WIDTH-1:0] base_c;
   logic [INPUT_WIDTH-1:0] pending_q, pending_d;
   logic [INPUT_WIDTH-1:0] ovf_q, ovf_d;
   logic [INPUT_WIDTH-1:0] req_c, hold_ok_c;
   logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
   logic [INDEX_WIDTH-1:0] idx_q, idx_d;
   logic [COUNT_WIDTH-1:0] ev_cnt_q, ev_cnt_d;
   logic                   valid_q, valid_d;
   logic                   load_c, issue_c;
   logic                   gnt_valid_c;
   logic [INDEX_WIDTH-1:0] gnt_index_c;

`ifdef EVENT_MERGE_SCHEDULER_HOLDOFF_EN
   logic [HOLDOFF_WIDTH-1:0] tmr_q [INPUT_WIDTH];
   logic [HOLDOFF_WIDTH-1:0] tmr_d [INPUT_WIDTH];

   always_comb begin
      hold_ok_c = '0;
      for (int i = 0; i < int'(INPUT_WIDTH); i++) hold_ok_c[i] = (tmr_q[i] == '0);
   end

   // Issuing reloads the source's timer; otherwise it counts down to zero.
   always_comb begin
      for (int i = 0; i < int'(INPUT_WIDTH); i++) begin
         tmr_d[i] = tmr_q[i];
         if (issue_c && (gnt_index_c == INDEX_WIDTH'(i))) tmr_d[i] = holdoff_time;
         else if (tmr_q[i] != '0)                         tmr_d[i] = tmr_q[i] - HOLDOFF_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(INPUT_WIDTH); i++) tmr_q[i] <= rst ? '0 : tmr_d[i];
   end
`else
   always_comb hold_ok_c = '1;
`endif

   always_comb begin
      req_c = '0;
      for (int i = 0; i < int'(INPUT_WIDTH); i++)
         req_c[i] = (cnt_q[i] != '0) && enable[i] && hold_ok_c[i];
   end

   event_merge_rr_select #(
      .N  (INPUT_WIDTH),
      .IW (INDEX_WIDTH)
   ) u_rr_select (
      .req_i         (req_c),
      .ptr_i         (ptr_q),
      .gnt_valid_c_o (gnt_valid_c),
      .gnt_index_c_o (gnt_index_c)
   );

   // Output register load, pointer advance and counter update.
   always_comb begin
      load_c    = !valid_q || m_event.m_event_ready;
      issue_c   = load_c && gnt_valid_c;
      valid_d   = valid_q;
      idx_d     = idx_q;
      ev_cnt_d  = ev_cnt_q;
      ptr_d     = ptr_q;
      ovf_d     = ovf_q;
      pending_d = '0;
      base_c    = '0;
      if (load_c) begin
         valid_d = gnt_valid_c;
         if (gnt_valid_c) begin
            idx_d    = gnt_index_c;
            ev_cnt_d = cnt_q[gnt_index_c];
            ptr_d    = (gnt_index_c == INDEX_WIDTH'(INPUT_WIDTH - 1)) ? '0
                                                                      : gnt_index_c + INDEX_WIDTH'(1);
         end
      end
      for (int i = 0; i < int'(INPUT_WIDTH); i++) begin
         base_c   = (issue_c && (gnt_index_c == INDEX_WIDTH'(i))) ? '0 : cnt_q[i];
         cnt_d[i] = base_c;
         if (pulse_in[i]) begin
            if (base_c == CNT_MAX) ovf_d[i] = 1'b1;
            else                   cnt_d[i] = base_c + COUNT_WIDTH'(1);
         end
         pending_d[i] = (cnt_d[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         idx_q     <= '0;
         ev_cnt_q  <= '0;
         ptr_q     <= '0;
         ovf_q     <= '0;
         pending_q <= '0;
         for (int i = 0; i < int'(INPUT_WIDTH); i++) cnt_q[i] <= '0;
      end else begin
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         ev_cnt_q  <= ev_cnt_d;
         ptr_q     <= ptr_d;
         ovf_q     <= ovf_d;
         pending_q <= pending_d;
         for (int i = 0; i < int'(INPUT_WIDTH); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign m_event.m_event_valid = valid_q;
   assign m_event.m_event_index = idx_q;
   assign m_event.m_event_count = ev_cnt_q;
   assign pending               = pending_q;
   assign overflow              = ovf_q;

endmodule
